// File: rtl/microwave_control.sv
// -----------------------------------------------------------------------------
// microwave_control
//   Keypad entry, countdown timer and magnetron control for a microwave oven.
//   Time is held as three BCD digits (M:ST). Button inputs are active-low levels
//   and are turned into single-cycle events on their falling edges.
//
// Ports
//   clk          system clock (rising edge)
//   resetn       synchronous reset, active-low
//   D[3:0]       BCD digit from keypad encoder, valid while loadn is low
//   loadn        key-valid strobe, active-low
//   startn       start button level, active-low
//   stopn        stop button level, active-low
//   clearn       clear button level, active-low
//   door_closed  1 = door closed
//   tick         one-clk pulse per second
//   enablen      keypad enable, active-low (low in IDLE/ENTRY)
//   mag_on       magnetron drive, registered, high only in COOK
//   done         cook finished indicator, high only in DONE
//   min_ones     display digit (BCD)
//   sec_tens     display digit (BCD)
//   sec_ones     display digit (BCD)
//   state[2:0]   IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4
// -----------------------------------------------------------------------------
module microwave_control (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       tick,
  output logic       enablen,
  output logic       mag_on,
  output logic       done,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] min_reg, tens_reg, ones_reg;
  logic [3:0] min_next, tens_next, ones_next;
  logic [3:0] dec_min, dec_tens, dec_ones;

  logic       loadn_reg, startn_reg, stopn_reg, clearn_reg;
  // Low for the first cycle after reset release so that a button already held
  // low when reset ends is absorbed into the edge-detect copy, not reported.
  logic       armed_reg;

  logic       mag_on_reg, done_reg, enablen_reg;

  logic       key_ev, start_ev, stop_ev, clear_ev;
  logic       time_zero;

  assign key_ev   = armed_reg & loadn_reg  & ~loadn;
  assign start_ev = armed_reg & startn_reg & ~startn;
  assign stop_ev  = armed_reg & stopn_reg  & ~stopn;
  assign clear_ev = armed_reg & clearn_reg & ~clearn;

  assign time_zero = (min_reg == 4'd0) && (tens_reg == 4'd0) && (ones_reg == 4'd0);

  // One-second BCD countdown; seconds tens borrow to 5 so the minute rolls
  // as M:00 -> (M-1):59, while entered tens values above 5 count down as-is.
  always_comb begin
    dec_min  = min_reg;
    dec_tens = tens_reg;
    dec_ones = ones_reg;
    if (ones_reg != 4'd0) begin
      dec_ones = ones_reg - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (tens_reg != 4'd0) begin
        dec_tens = tens_reg - 4'd1;
      end else begin
        dec_tens = 4'd5;
        dec_min  = min_reg - 4'd1;
      end
    end
  end

  // Next-state and digit update. The if-chain order is the event priority:
  // only the highest applicable event acts, lower ones are dropped.
  always_comb begin
    state_next = state_reg;
    min_next   = min_reg;
    tens_next  = tens_reg;
    ones_next  = ones_reg;

    if (state_reg == S_COOK && !door_closed) begin
      state_next = S_PAUSE;
    end else if (stop_ev && state_reg != S_IDLE) begin
      if (state_reg == S_COOK) begin
        state_next = S_PAUSE;
      end else begin
        state_next = S_IDLE;
        min_next   = 4'd0;
        tens_next  = 4'd0;
        ones_next  = 4'd0;
      end
    end else if (clear_ev && state_reg != S_COOK) begin
      state_next = S_IDLE;
      min_next   = 4'd0;
      tens_next  = 4'd0;
      ones_next  = 4'd0;
    end else if (start_ev && door_closed &&
                 ((state_reg == S_ENTRY && !time_zero) || state_reg == S_PAUSE)) begin
      state_next = S_COOK;
    end else if (tick && state_reg == S_COOK) begin
      min_next  = dec_min;
      tens_next = dec_tens;
      ones_next = dec_ones;
      if (dec_min == 4'd0 && dec_tens == 4'd0 && dec_ones == 4'd0) begin
        state_next = S_DONE;
      end
    end else if (key_ev && (state_reg == S_IDLE || state_reg == S_ENTRY) && D <= 4'd9) begin
      min_next   = tens_reg;
      tens_next  = ones_reg;
      ones_next  = D;
      state_next = S_ENTRY;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= S_IDLE;
      min_reg     <= 4'd0;
      tens_reg    <= 4'd0;
      ones_reg    <= 4'd0;
      loadn_reg   <= 1'b1;
      startn_reg  <= 1'b1;
      stopn_reg   <= 1'b1;
      clearn_reg  <= 1'b1;
      armed_reg   <= 1'b0;
      mag_on_reg  <= 1'b0;
      done_reg    <= 1'b0;
      enablen_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      min_reg     <= min_next;
      tens_reg    <= tens_next;
      ones_reg    <= ones_next;
      loadn_reg   <= loadn;
      startn_reg  <= startn;
      stopn_reg   <= stopn;
      clearn_reg  <= clearn;
      armed_reg   <= 1'b1;
      // Status outputs are registered from the next state so they line up
      // with state without any combinational path from the inputs.
      mag_on_reg  <= (state_next == S_COOK);
      done_reg    <= (state_next == S_DONE);
      enablen_reg <= !(state_next == S_IDLE || state_next == S_ENTRY);
    end
  end

  assign state    = state_reg;
  assign min_ones = min_reg;
  assign sec_tens = tens_reg;
  assign sec_ones = ones_reg;
  assign mag_on   = mag_on_reg;
  assign done     = done_reg;
  assign enablen  = enablen_reg;

endmodule

// File: tb/tb_microwave_control.sv
module tb_microwave_control;

  logic       clk;
  logic       resetn;
  logic [3:0] D;
  logic       loadn, startn, stopn, clearn, door_closed, tick;
  logic       enablen, mag_on, done;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  microwave_control dut (
    .clk(clk), .resetn(resetn), .D(D), .loadn(loadn), .startn(startn),
    .stopn(stopn), .clearn(clearn), .door_closed(door_closed), .tick(tick),
    .enablen(enablen), .mag_on(mag_on), .done(done), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Time is a plain integer MST (e.g. 130 = 1:30). A key appends a decimal
  // digit; a tick subtracts one second, borrowing a minute as M00 -> (M-1)59.
  int m_state = 0;
  int m_n     = 0;
  bit m_ready = 0;
  bit m_valid = 0;
  bit pl = 1, ps = 1, pp = 1, pc = 1;

  always @(posedge clk) begin
    bit ke, se, pe, ce;
    if (!resetn) begin
      m_state = 0; m_n = 0; m_ready = 0; m_valid = 1;
      pl = 1; ps = 1; pp = 1; pc = 1;
    end else begin
      ke = m_ready && pl && !loadn;
      se = m_ready && ps && !startn;
      pe = m_ready && pp && !stopn;
      ce = m_ready && pc && !clearn;
      if (m_state == 2 && !door_closed) m_state = 3;
      else if (pe && m_state != 0) begin
        if (m_state == 2) m_state = 3;
        else begin m_state = 0; m_n = 0; end
      end
      else if (ce && m_state != 2) begin m_state = 0; m_n = 0; end
      else if (se && door_closed && ((m_state == 1 && m_n != 0) || m_state == 3)) m_state = 2;
      else if (tick && m_state == 2) begin
        m_n = (m_n % 100 == 0) ? m_n - 41 : m_n - 1;
        if (m_n == 0) m_state = 4;
      end
      else if (ke && m_state <= 1 && int'(D) <= 9) begin
        m_n = (m_n % 100) * 10 + int'(D);
        m_state = 1;
      end
      m_ready = 1;
      pl = loadn; ps = startn; pp = stopn; pc = clearn;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [17:0] exp_v, got_v;
    if (m_valid) begin
      exp_v = {3'(m_state), 1'(m_state >= 2), 1'(m_state == 2), 1'(m_state == 4),
               4'(m_n / 100), 4'((m_n / 10) % 10), 4'(m_n % 10)};
      got_v = {state, enablen, mag_on, done, min_ones, sec_tens, sec_ones};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs t=%0t got=%h required=%h", $time, got_v, exp_v);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input int got, input int exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", nm, got, exp_v);
    end else
      $display("ok   %s = %h", nm, got);
  endtask

  task automatic key(input logic [3:0] d);
    @(negedge clk); #1 D = d; loadn = 1'b0;
    repeat (2) @(negedge clk);
    #1 loadn = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_start();
    @(negedge clk); #1 startn = 1'b0;
    repeat (2) @(negedge clk);
    #1 startn = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_stop();
    @(negedge clk); #1 stopn = 1'b0;
    repeat (2) @(negedge clk);
    #1 stopn = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_clear();
    @(negedge clk); #1 clearn = 1'b0;
    repeat (2) @(negedge clk);
    #1 clearn = 1'b1;
    @(negedge clk);
  endtask

  task automatic one_tick();
    @(negedge clk); #1 tick = 1'b1;
    @(negedge clk); #1 tick = 1'b0;
    @(negedge clk);
  endtask

  function automatic int digits();
    return int'({min_ones, sec_tens, sec_ones});
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    resetn = 1'b0; D = 4'd0; loadn = 1'b1; startn = 1'b1; stopn = 1'b1;
    clearn = 1'b1; door_closed = 1'b1; tick = 1'b0;
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_outs", int'({enablen, mag_on, done}), 0);
    chk("reset_digits", digits(), 'h000);

    // 1:30 countdown across the minute boundary
    key(4'd1); key(4'd3); key(4'd0);
    chk("entry_130", digits(), 'h130);
    press_start();
    chk("cook_state", int'(state), 2);
    chk("cook_mag", int'(mag_on), 1);
    one_tick();
    chk("tick_129", digits(), 'h129);
    repeat (29) one_tick();
    chk("tick_100", digits(), 'h100);
    one_tick();
    chk("tick_059", digits(), 'h059);
    press_stop(); press_stop();
    chk("stop_idle", int'(state), 0);

    // 0:02 down to DONE
    key(4'd0); key(4'd2);
    press_start();
    one_tick();
    chk("tick_001", digits(), 'h001);
    one_tick();
    chk("done_digits", digits(), 'h000);
    chk("done_flags", int'({state, mag_on, done}), {3'd4, 1'b0, 1'b1});
    press_clear();
    chk("clear_idle", int'({state, done}), 0);

    // Door open while cooking at 0:45
    key(4'd4); key(4'd5);
    press_start();
    @(negedge clk); #1 door_closed = 1'b0;
    repeat (2) @(negedge clk);
    chk("door_pause", int'({state, mag_on}), {3'd3, 1'b0});
    one_tick();
    chk("pause_tick", digits(), 'h045);
    #1 door_closed = 1'b1;
    press_start();
    chk("resume_cook", int'(state), 2);
    one_tick();
    chk("resume_044", digits(), 'h044);
    press_stop(); press_stop();

    // Shift-out of the oldest digit, illegal key, start with door open
    key(4'd4); key(4'd5); key(4'd6); key(4'd7);
    chk("entry_567", digits(), 'h567);
    key(4'd12);
    chk("bad_key", digits(), 'h567);
    #1 door_closed = 1'b0;
    press_start();
    chk("start_door_open", int'(state), 1);
    #1 door_closed = 1'b1;
    press_clear();

    // 0:90 counts through non-standard tens
    key(4'd9); key(4'd0);
    press_start();
    one_tick();
    chk("tick_089", digits(), 'h089);
    press_stop(); press_stop();

    // Stop and tick together at 0:10
    key(4'd1); key(4'd0);
    press_start();
    @(negedge clk); #1 stopn = 1'b0; tick = 1'b1;
    @(negedge clk); #1 tick = 1'b0;
    @(negedge clk); #1 stopn = 1'b1;
    @(negedge clk);
    chk("stop_tick_state", int'(state), 3);
    chk("stop_tick_digits", digits(), 'h010);
    press_stop();
    chk("stop2_idle", int'({state, min_ones, sec_tens, sec_ones}), 0);

    // Reset mid-cook with start held low through reset release
    key(4'd5);
    press_start();
    @(negedge clk); #1 startn = 1'b0;
    @(negedge clk); #1 resetn = 1'b0;
    @(negedge clk);
    chk("reset_mag_off", int'(mag_on), 0);
    #1 resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset", int'({state, mag_on, min_ones, sec_tens, sec_ones}), 0);
    #1 startn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
